// File: rtl/tree_rom_pkg.sv
// -----------------------------------------------------------------------------
// tree_rom_pkg
// Shared definitions for the tree sprite ROM arbiter: default geometry of the
// 48x76 RGB sprite ROM, the transparent colour returned for out-of-range
// reads, and the burst FSM state encoding.
// -----------------------------------------------------------------------------
package tree_rom_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int ADDR_W_DEF    = 14;
  localparam int DATA_W_DEF    = 24;
  localparam int ROM_DEPTH_DEF = 3648;
  localparam int BURST_LEN_DEF = 48;

  // Fully-set colour is treated as transparent by the renderer.
  localparam logic [23:0] TRANSPARENT = 24'hFFFFFF;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/tree_rom_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Round-robin search over requesters 1..N-1. The search starts at ptr_i and
// wraps back to index 1; bit 0 of req_i is never considered.
// Ports:
//   req_i   in  N   request mask
//   ptr_i   in  PW  first index to consider (1..N-1)
//   gnt_o   out N   one-hot grant, zero when nothing found
//   idx_o   out PW  index of the granted requester
//   found_o out 1   a requester was found
// -----------------------------------------------------------------------------
module rr_picker
  import tree_rom_pkg::*;
#(
  parameter int N  = NUM_REQ_DEF,
  parameter int PW = $clog2(NUM_REQ_DEF)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          found_o
);

  // Two passes: indices at or above the pointer first, then the wrapped part.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = 1; i < N; i++) begin
      if (!found_o && req_i[i] && (i >= int'(ptr_i))) begin
        found_o  = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = PW'(i);
      end else begin
        found_o = found_o;
      end
    end
    for (int i = 1; i < N; i++) begin
      if (!found_o && req_i[i] && (i < int'(ptr_i))) begin
        found_o  = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = PW'(i);
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/tree_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tree_rom_arbiter
// Shares the single tree sprite ROM read port. Requester 0 (display) has
// absolute priority; the others are served round-robin, optionally in bursts
// of up to BURST_LEN back-to-back beats. Responses return one cycle after the
// grant; out-of-range reads return TRANSPARENT with rsp_err_o set.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   req_valid_i [N]   request pending per requester
//   req_burst_i [N]   request opens a burst (first beat only)
//   req_addr_i  [N][ADDR_W] read address per requester
//   req_ready_o [N]   combinational one-hot grant
//   rom_addr_o        ROM read address (0 when idle)
//   rom_data_i        ROM data, valid the cycle after the address
//   rsp_valid_o [N]   one-hot response strobe
//   rsp_data_o        response colour (0 when no response)
//   rsp_err_o         response was for an out-of-range address
// -----------------------------------------------------------------------------
module tree_rom_arbiter
  import tree_rom_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ROM_DEPTH = ROM_DEPTH_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ-1:0]             req_burst_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [ADDR_W-1:0]              rom_addr_o,
  input  logic [DATA_W-1:0]              rom_data_i,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  output logic [DATA_W-1:0]              rsp_data_o,
  output logic                           rsp_err_o
);

  localparam int PW    = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  // A one-beat burst is just a single read, so the FSM never enters BURST.
  localparam logic BURST_EN = (BURST_LEN > 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(ROM_DEPTH);

  state_e               state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic                 rsp_oob_q;

  logic [NUM_REQ-1:0]   rr_mask_s, rr_gnt_s, gnt_s;
  logic [PW-1:0]        rr_idx_s, gnt_idx_s;
  logic                 rr_found_s, rr_take_s, gnt_any_s, burst_live_s, oob_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] k);
    if (k == PW'(NUM_REQ - 1)) begin
      return PW'(1);
    end else begin
      return k + PW'(1);
    end
  endfunction

  assign rr_mask_s = {req_valid_i[NUM_REQ-1:1], 1'b0};

  rr_picker #(.N(NUM_REQ), .PW(PW)) u_rr_picker (
    .req_i   (rr_mask_s),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (rr_gnt_s),
    .idx_o   (rr_idx_s),
    .found_o (rr_found_s)
  );

  // Grant selection: display path, then live burst owner, then round-robin.
  always_comb begin
    gnt_s        = '0;
    gnt_idx_s    = '0;
    gnt_any_s    = 1'b0;
    rr_take_s    = 1'b0;
    burst_live_s = (state_q == BURST) && req_valid_i[owner_q];
    if (req_valid_i[0]) begin
      gnt_s[0]  = 1'b1;
      gnt_any_s = 1'b1;
    end else if (burst_live_s) begin
      gnt_s[owner_q] = 1'b1;
      gnt_idx_s      = owner_q;
      gnt_any_s      = 1'b1;
    end else if (rr_found_s) begin
      gnt_s     = rr_gnt_s;
      gnt_idx_s = rr_idx_s;
      gnt_any_s = 1'b1;
      rr_take_s = 1'b1;
    end else begin
      gnt_any_s = 1'b0;
    end
  end

  assign req_ready_o = gnt_s;
  assign rom_addr_o  = gnt_any_s ? req_addr_i[gnt_idx_s] : '0;
  assign oob_s       = gnt_any_s && ({1'b0, rom_addr_o} >= DEPTH_L);

  // Burst FSM and round-robin pointer next-state.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      BURST: begin
        if (!req_valid_i[owner_q]) begin
          // Owner abandoned the burst; round-robin takes over this cycle.
          state_d    = IDLE;
          beat_cnt_d = '0;
          rr_ptr_d   = next_ptr(owner_q);
        end else if (!req_valid_i[0]) begin
          // Owner beat; beat_cnt counts beats still to come after this one.
          if (beat_cnt_q <= CNT_W'(1)) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            rr_ptr_d   = next_ptr(owner_q);
          end else begin
            beat_cnt_d = beat_cnt_q - CNT_W'(1);
          end
        end else begin
          // Display grant pauses the burst.
          state_d = BURST;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (rr_take_s) begin
      if (BURST_EN && req_burst_i[rr_idx_s]) begin
        state_d    = BURST;
        owner_d    = rr_idx_s;
        beat_cnt_d = CNT_W'(BURST_LEN - 1);
      end else begin
        rr_ptr_d = next_ptr(rr_idx_s);
      end
    end else begin
      rr_ptr_d = rr_ptr_d;
    end
  end

  // State, pointer and response pipeline registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_ptr_q    <= PW'(1);
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      rsp_valid_q <= '0;
      rsp_oob_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      rsp_valid_q <= gnt_s;
      rsp_oob_q   <= oob_s;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_oob_q;
  // ROM data arrives the cycle after the address, alongside the registered strobe.
  assign rsp_data_o  = (|rsp_valid_q) ? (rsp_oob_q ? DATA_W'(TRANSPARENT) : rom_data_i)
                                      : '0;

endmodule

// File: tb/tb_tree_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tree_rom_arbiter
// Directed scenarios followed by randomized traffic, checked against a
// behavioural arbitration model (integer pointer, remaining-beat counter).
// -----------------------------------------------------------------------------
module tb_tree_rom_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 24;
  localparam int ROM_DEPTH = 3648;
  localparam int BURST_LEN = 48;

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_burst;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]             req_ready;
  logic [ADDR_W-1:0]              rom_addr;
  logic [DATA_W-1:0]              rom_data = '0;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_data;
  logic                           rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: rr pointer, burst owner (0 = none), beats still owed
  int m_rr = 1;
  int m_owner = 0;
  int m_left = 0;
  int pend_g = -1;
  logic [ADDR_W-1:0] pend_a = '0;
  logic [NUM_REQ-1:0] last_ready = '0;

  tree_rom_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .ROM_DEPTH(ROM_DEPTH), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_burst_i (req_burst),
    .req_addr_i  (req_addr),
    .req_ready_o (req_ready),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return {a[5:0] ^ 6'h2A, a, 4'h9} ^ 24'h35C0A1;
  endfunction

  // ROM with one cycle read latency
  always @(posedge clk) rom_data <= rom_word(rom_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nxt(input int k);
    return (k >= NUM_REQ - 1) ? 1 : k + 1;
  endfunction

  task automatic model_reset();
    m_rr = 1; m_owner = 0; m_left = 0; pend_g = -1; pend_a = '0;
  endtask

  // Decide this cycle's winner from the rules, then advance model state.
  task automatic model_step(output int eg);
    eg = -1;
    if (req_valid[0]) eg = 0;
    else if (m_owner > 0 && req_valid[m_owner]) eg = m_owner;
    else begin
      for (int o = 0; o < NUM_REQ - 1; o++) begin
        int c;
        c = 1 + ((m_rr - 1 + o) % (NUM_REQ - 1));
        if (eg < 0 && req_valid[c]) eg = c;
      end
    end
    if (m_owner > 0 && !req_valid[m_owner]) begin
      m_rr = nxt(m_owner);
      m_owner = 0;
    end
    if (eg > 0 && eg == m_owner) begin
      m_left--;
      if (m_left == 0) begin
        m_owner = 0;
        m_rr = nxt(eg);
      end
    end else if (eg > 0) begin
      if (req_burst[eg] && BURST_LEN > 1) begin
        m_owner = eg;
        m_left = BURST_LEN - 1;
      end else begin
        m_rr = nxt(eg);
      end
    end
  endtask

  // One cycle: inputs already driven at the negedge; check, then clock.
  task automatic step();
    int eg;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    #1;
    model_step(eg);
    ea = (eg < 0) ? '0 : req_addr[eg];
    check_eq("req_ready", 32'(req_ready), (eg < 0) ? 32'd0 : (32'd1 << eg));
    check_eq("rom_addr", 32'(rom_addr), 32'(ea));
    check_eq("rsp_valid", 32'(rsp_valid), (pend_g < 0) ? 32'd0 : (32'd1 << pend_g));
    if (pend_g < 0) ed = '0;
    else if (pend_a >= ROM_DEPTH) ed = 24'hFFFFFF;
    else ed = rom_word(pend_a);
    check_eq("rsp_data", 32'(rsp_data), 32'(ed));
    check_eq("rsp_err", 32'(rsp_err), 32'(pend_g >= 0 && pend_a >= ROM_DEPTH));
    last_ready = req_ready;
    pend_g = eg;
    pend_a = ea;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic new_req(input int r);
    req_valid[r] = 1'b1;
    req_addr[r]  = ADDR_W'($urandom_range(0, 3700));
    req_burst[r] = ($urandom_range(0, 5) == 0);
  endtask

  task automatic check_outputs_idle(input string tag);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check_eq({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
  endtask

  initial begin
    int order [7];
    int beats;
    int rsp1;
    int guard;
    order = '{1, 2, 3, 1, 2, 3, 1};

    rst_n = 1'b0;
    req_valid = '0; req_burst = '0; req_addr = '0;
    @(negedge clk);
    @(negedge clk);
    check_outputs_idle("reset");
    rst_n = 1'b1;
    model_reset();

    // single read by requester 2
    req_valid[2] = 1'b1; req_addr[2] = 14'd5;
    step();
    check_eq("t1_grant", 32'(last_ready), 32'h4);
    req_valid = '0;
    check_eq("t1_rsp_valid", 32'(rsp_valid), 32'h4);
    check_eq("t1_rsp_data", 32'(rsp_data), 32'(rom_word(14'd5)));
    step();

    // out-of-range read by requester 3
    req_valid[3] = 1'b1; req_addr[3] = 14'd3648;
    step();
    req_valid = '0;
    check_eq("oob_valid", 32'(rsp_valid), 32'h8);
    check_eq("oob_data", 32'(rsp_data), 32'hFFFFFF);
    check_eq("oob_err", 32'(rsp_err), 32'd1);
    step();

    // reset right after a grant drops the in-flight response
    req_valid[2] = 1'b1; req_addr[2] = 14'd100;
    step();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check_outputs_idle("midreset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // round-robin among 1..3 starting from the reset pointer
    req_valid = 4'b1110;
    req_addr[1] = 14'd11; req_addr[2] = 14'd22; req_addr[3] = 14'd33;
    for (int i = 0; i < 7; i++) begin
      step();
      check_eq("rr_order", 32'(last_ready), 32'd1 << order[i]);
    end
    req_valid = '0;
    step();

    // burst of 48 by requester 1 with a display read inserted at beat 10
    beats = 0; rsp1 = 0; guard = 0;
    req_burst[1] = 1'b1;
    while (rsp1 < BURST_LEN && guard < 120) begin
      req_valid[1] = (beats < BURST_LEN);
      req_addr[1]  = ADDR_W'(beats);
      req_valid[0] = (beats == 10 && req_addr[0] != 14'd777);
      if (req_valid[0]) req_addr[0] = 14'd777;
      step();
      if (req_valid[0]) check_eq("r0_insert", 32'(last_ready), 32'h1);
      req_valid[0] = 1'b0;
      if (last_ready[1]) beats++;
      if (rsp_valid[1]) begin
        check_eq("burst_order", 32'(rsp_data), 32'(rom_word(ADDR_W'(rsp1))));
        rsp1++;
      end
      guard++;
    end
    check_eq("burst_rsps", 32'(rsp1), 32'(BURST_LEN));
    check_eq("burst_beats", 32'(beats), 32'(BURST_LEN));
    req_valid = '0; req_burst = '0; req_addr[0] = '0;
    step();

    // burst owner 2 drops valid while requester 3 waits
    req_valid[2] = 1'b1; req_burst[2] = 1'b1; req_addr[2] = 14'd200;
    step();
    req_valid[3] = 1'b1; req_addr[3] = 14'd300;
    for (int i = 0; i < 3; i++) begin
      req_addr[2] = req_addr[2] + 14'd1;
      step();
      check_eq("t6_owner", 32'(last_ready), 32'h4);
    end
    req_valid[2] = 1'b0; req_burst[2] = 1'b0;
    step();
    check_eq("t6_drop_grant", 32'(last_ready), 32'h8);
    req_valid = '0;
    req_valid[1] = 1'b1; req_valid[2] = 1'b1; req_addr[1] = 14'd7;
    step();
    check_eq("t6_idle", 32'(last_ready), 32'h2);
    req_valid = '0;
    step();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      req_valid[0] = ($urandom_range(0, 3) == 0);
      req_addr[0]  = ADDR_W'($urandom_range(0, 3700));
      req_burst[0] = 1'($urandom_range(0, 1));
      for (int r = 1; r < NUM_REQ; r++) begin
        if (req_valid[r] && last_ready[r]) begin
          if (m_owner == r && $urandom_range(0, 39) != 0) req_addr[r] = req_addr[r] + 14'd1;
          else if ($urandom_range(0, 2) == 0) new_req(r);
          else req_valid[r] = 1'b0;
        end else if (req_valid[r]) begin
          if ($urandom_range(0, 29) == 0) req_valid[r] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          new_req(r);
        end
      end
      step();
    end
    req_valid = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tree_rom_arbiter.md
# tree_rom_arbiter

Shares the single read port of the tree sprite ROM among several requesters: the display path, which must never stall, plus lower-priority clients such as collision and minimap fetch. Arbitration is fixed priority for requester 0 and round-robin among the rest. Optional short bursts let a client fetch a sprite row back-to-back. The block drives the ROM address each cycle and returns the ROM's 24-bit colour, one cycle later, to the requester that was granted.

## Interface
- NUM_REQ, 4: number of requesters; index 0 is the display path (2..8)
- ADDR_W, 14: ROM address width
- DATA_W, 24: RGB colour width
- ROM_DEPTH, 3648: valid addresses 0..ROM_DEPTH-1 (48x76 sprite)
- BURST_LEN, 48: maximum beats in one burst (one sprite row)
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  request pending, per requester
- req_burst  in  NUM_REQ  request opens a burst, sampled on the first beat only
- req_addr  in  NUM_REQ x ADDR_W  read address; must be held stable while valid and not ready
- req_ready  out  NUM_REQ  grant; one-hot or zero; combinational
- rom_addr  out  ADDR_W  to ROM read_address
- rom_data  in  DATA_W  from ROM data_out; valid the cycle after an address is presented
- rsp_valid  out  NUM_REQ  response strobe, one-hot or zero
- rsp_data  out  DATA_W  colour for the strobed requester
- rsp_err  out  1  high with rsp_valid when the granted address was >= ROM_DEPTH

## Operation
- A transfer occurs on req_valid[i] && req_ready[i]. At most one grant per cycle.
- Grant priority:
  - Requester 0 always wins when it is valid.
  - Otherwise the active burst owner wins, if it is valid.
  - Otherwise round-robin over 1..NUM_REQ-1, starting at rr_ptr.
- rr_ptr: after a non-burst grant to k >= 1, rr_ptr = k+1, wrapping to 1. A grant to 0 leaves rr_ptr unchanged.
- FSM with states IDLE and BURST:
  - IDLE -> BURST on a grant to k >= 1 with req_burst[k]=1. beat_cnt loads BURST_LEN-1 and owner = k.
  - In BURST, each owner grant decrements beat_cnt. At beat_cnt==0 with a grant, go to IDLE and set rr_ptr = owner+1 (wrapped).
  - Owner drops req_valid in BURST: the burst ends (-> IDLE) and round-robin applies in the same cycle.
  - A requester 0 grant during BURST pauses the burst. beat_cnt and owner are held.
  - Requester 0 bursts are ignored; req_burst[0] is a don't-care.
- rom_addr = address of the granted requester, or 0 when there is no grant.
- Out-of-range address: the request is granted normally. The response returns rsp_data = 24'hFFFFFF (transparent) with rsp_err=1, and rom_data is ignored.
- Response: the registered grant id and the oob flag select the rsp_valid bit in the following cycle. rsp_data = rom_data, or 24'hFFFFFF if oob. When rsp_valid is 0, rsp_data is 0.
- Requesters never backpressure responses.

## Timing
- Read latency: exactly 1 cycle from the grant edge to rsp_valid.
- Throughput: 1 grant per cycle, sustained.
- Requester 0 is granted in the same cycle it asserts valid. Its worst-case latency is 1 cycle.
- Lower requesters may starve while requester 0 is continuously valid; this is by design. Otherwise each waits at most (NUM_REQ-2)*BURST_LEN + NUM_REQ-2 grants.
- Reset values: rsp_valid=0, rsp_data=0, rsp_err=0, state=IDLE, rr_ptr=1, beat_cnt=0, owner=0. req_ready and rom_addr follow the inputs combinationally; with all valids low, they are 0.
- Reset asserted mid-operation drops any in-flight response and any burst. Requesters re-issue after reset.
- Same-cycle events: a burst's final beat plus a new valid elsewhere means the new requester is eligible on the next cycle.

## Structure
- tree_rom_pkg holds:
  - ROM_DEPTH, ADDR_W and DATA_W defaults
  - TRANSPARENT = 24'hFFFFFF
  - the state enum (IDLE, BURST)
- Sub-module rr_picker holds the round-robin search. It takes a request mask and a pointer and returns a one-hot grant plus a found flag.

## Test plan
- Requester 2 alone reads addr 5 -> req_ready[2] in the same cycle, rom_addr=5, then rsp_valid[2] with rsp_data equal to ROM word 5 on the next cycle.
- Requesters 1, 2 and 3 continuously valid, no burst -> grants in order 1, 2, 3, 1, 2, ...; rr_ptr wraps to 1.
- Requester 1 bursts addrs 0..47 while requester 0 pulses valid at beat 10 -> the 0 grant is inserted, the burst resumes at beat 10, and 48 responses reach requester 1 in order.
- Requester 3 reads addr 3648 -> rsp_data=24'hFFFFFF, rsp_err=1, rsp_valid[3].
- Assert Reset_n low on the cycle after a grant -> no rsp_valid, and all outputs at reset values.
- Requester 2 drops valid mid-burst while requester 3 is waiting -> requester 3 is granted that cycle and the FSM returns to IDLE.
